thread_scheduler: RTL and testbench

THREAD_SCHEDULER -- requirements
Module: thread_scheduler

---
 rtl/thread_scheduler_pkg.sv | 15 +
 rtl/thread_scheduler_thread_state.sv | 64 ++++++
 rtl/thread_scheduler.sv | 97 +++++++++
 tb/tb_thread_scheduler.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/thread_scheduler_pkg.sv
// Shared processor definitions for the fetch thread scheduler: thread count,
// thread index width and the per-thread scheduling state.
package thread_scheduler_pkg;

    localparam int NUM_THREADS  = 4;
    localparam int THREAD_WIDTH = 2;

    typedef enum logic [1:0] {
        TS_IDLE      = 2'd0,
        TS_READY     = 2'd1,
        TS_WAIT_FILL = 2'd2,
        TS_PENALTY   = 2'd3
    } thread_state_e;

endpackage

// File: rtl/thread_scheduler_thread_state.sv
// Per-thread fetch state: tracks I-cache misses and redirect penalties so the
// arbiter only has to look at whether the thread is READY.
module thread_state
    import thread_scheduler_pkg::*;
#(
    parameter int PENALTY_CYCLES = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          active_i,
    input  logic          miss_i,
    input  logic          fill_i,
    input  logic          redirect_i,
    output thread_state_e state_o
);

    // The redirect cycle itself is the first blocked cycle, so the counter
    // holds only the blocked cycles still to come once PENALTY is entered.
    localparam logic [3:0]    RELOAD         = 4'(PENALTY_CYCLES - 1);
    localparam thread_state_e AFTER_REDIRECT = (RELOAD == 4'd0) ? TS_READY : TS_PENALTY;

    thread_state_e state_q;
    logic [3:0]    cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || !active_i) begin
            state_q <= TS_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            case (state_q)
                TS_IDLE: begin
                    state_q <= TS_READY;
                end
                TS_READY, TS_WAIT_FILL: begin
                    if (redirect_i) begin
                        state_q <= AFTER_REDIRECT;
                        cnt_q   <= RELOAD;
                    end else if (state_q == TS_READY && miss_i) begin
                        state_q <= TS_WAIT_FILL;
                    end else if (state_q == TS_WAIT_FILL && fill_i) begin
                        state_q <= TS_READY;
                    end
                end
                TS_PENALTY: begin
                    if (redirect_i) begin
                        state_q <= AFTER_REDIRECT;
                        cnt_q   <= RELOAD;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q <= 4'd1) begin
                            state_q <= TS_READY;
                        end
                    end
                end
                default: begin
                    state_q <= TS_IDLE;
                end
            endcase
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/thread_scheduler.sv
// Round-robin fetch thread scheduler: per-thread state machines feed a
// registered one-hot grant with stall/flush control.
module thread_scheduler #(
    parameter int NUM_THREADS    = thread_scheduler_pkg::NUM_THREADS,
    parameter int THREAD_WIDTH   = thread_scheduler_pkg::THREAD_WIDTH,
    parameter int PENALTY_CYCLES = 3
) (
    input  logic                    i_Clk,
    input  logic                    i_Reset,
    input  logic                    i_Stall,
    input  logic                    i_Flush,
    input  logic [NUM_THREADS-1:0]  i_active,
    input  logic [NUM_THREADS-1:0]  i_miss,
    input  logic [NUM_THREADS-1:0]  i_fill,
    input  logic [NUM_THREADS-1:0]  i_redirect,
    output logic [THREAD_WIDTH-1:0] o_thread,
    output logic [NUM_THREADS-1:0]  o_grant,
    output logic                    o_valid
);
    import thread_scheduler_pkg::*;

    thread_state_e            state [NUM_THREADS];
    logic [NUM_THREADS-1:0]   elig;

    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thr
        thread_state #(
            .PENALTY_CYCLES(PENALTY_CYCLES)
        ) u_state (
            .clk_i      (i_Clk),
            .rst_i      (i_Reset),
            .active_i   (i_active[t]),
            .miss_i     (i_miss[t]),
            .fill_i     (i_fill[t]),
            .redirect_i (i_redirect[t]),
            .state_o    (state[t])
        );
        // Same-cycle events veto the grant before the state machine reacts.
        assign elig[t] = (state[t] == TS_READY) & i_active[t] & ~i_miss[t] & ~i_redirect[t];
    end

    logic [THREAD_WIDTH-1:0] ptr_q, ptr_d;
    logic [THREAD_WIDTH-1:0] thread_q, thread_d;
    logic [NUM_THREADS-1:0]  grant_q, grant_d;
    logic                    valid_q, valid_d;
    logic [THREAD_WIDTH-1:0] sel, idx;
    logic                    found;

    always_comb begin
        found = 1'b0;
        sel   = ptr_q;
        idx   = ptr_q;
        for (int k = 0; k < NUM_THREADS; k++) begin
            idx = ptr_q + THREAD_WIDTH'(k);
            if (!found && elig[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        ptr_d    = ptr_q;
        thread_d = thread_q;
        grant_d  = grant_q;
        valid_d  = valid_q;
        if (!i_Stall) begin
            if (i_Flush || !found) begin
                valid_d = 1'b0;
                grant_d = '0;
            end else begin
                valid_d  = 1'b1;
                thread_d = sel;
                grant_d  = NUM_THREADS'(1) << sel;
                ptr_d    = sel + THREAD_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            ptr_q    <= '0;
            thread_q <= '0;
            grant_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            thread_q <= thread_d;
            grant_q  <= grant_d;
            valid_q  <= valid_d;
        end
    end

    assign o_thread = thread_q;
    assign o_grant  = grant_q;
    assign o_valid  = valid_q;

endmodule

// File: tb/tb_thread_scheduler.sv
// Scoreboard bench for thread_scheduler: directed scenarios plus random
// traffic, checked against a behavioural per-thread model.
module tb_thread_scheduler;

    localparam int P = 3;

    logic       clk = 1'b0;
    logic       rst, stall, flush;
    logic [3:0] act, miss, fill, redir;
    logic [1:0] o_thread;
    logic [3:0] o_grant;
    logic       o_valid;

    always #5 clk = ~clk;

    thread_scheduler #(
        .NUM_THREADS(4),
        .THREAD_WIDTH(2),
        .PENALTY_CYCLES(P)
    ) dut (
        .i_Clk      (clk),
        .i_Reset    (rst),
        .i_Stall    (stall),
        .i_Flush    (flush),
        .i_active   (act),
        .i_miss     (miss),
        .i_fill     (fill),
        .i_redirect (redir),
        .o_thread   (o_thread),
        .o_grant    (o_grant),
        .o_valid    (o_valid)
    );

    typedef struct packed {
        logic       valid;
        logic [3:0] grant;
        logic [1:0] thread;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Model: a thread is "present" one cycle after it is enabled, may be
    // waiting for a fill, and may owe some further blocked cycles.
    bit       m_present[4];
    bit       m_wait[4];
    int       m_pen[4];
    int       m_ptr;
    bit       m_valid;
    int       m_thread;
    bit [3:0] m_grant;

    task automatic model_step(input bit r, input bit s, input bit f, input bit [3:0] a,
                              input bit [3:0] mi, input bit [3:0] fi, input bit [3:0] rd);
        exp_t e;
        bit   el[4];
        bit   found;
        int   pick;
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                m_present[i] = 0;
                m_wait[i]    = 0;
                m_pen[i]     = 0;
            end
            m_ptr    = 0;
            m_valid  = 0;
            m_grant  = 4'b0;
            m_thread = 0;
        end else begin
            for (int i = 0; i < 4; i++)
                el[i] = a[i] && m_present[i] && !m_wait[i] && m_pen[i] == 0 && !mi[i] && !rd[i];
            if (!s) begin
                found = 0;
                pick  = 0;
                for (int k = 0; k < 4; k++) begin
                    if (!found && el[(m_ptr + k) % 4]) begin
                        found = 1;
                        pick  = (m_ptr + k) % 4;
                    end
                end
                if (f || !found) begin
                    m_valid = 0;
                    m_grant = 4'b0;
                end else begin
                    m_valid  = 1;
                    m_thread = pick;
                    m_grant  = 4'b0001 << pick;
                    m_ptr    = (pick + 1) % 4;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (!a[i]) begin
                    m_present[i] = 0;
                    m_wait[i]    = 0;
                    m_pen[i]     = 0;
                end else if (!m_present[i]) begin
                    m_present[i] = 1;
                end else if (rd[i]) begin
                    m_wait[i] = 0;
                    m_pen[i]  = P - 1;
                end else if (m_pen[i] > 0) begin
                    m_pen[i] = m_pen[i] - 1;
                end else if (m_wait[i]) begin
                    if (fi[i]) m_wait[i] = 0;
                end else if (mi[i]) begin
                    m_wait[i] = 1;
                end
            end
        end
        e.valid  = m_valid;
        e.grant  = m_grant;
        e.thread = 2'(m_thread);
        exp_q.push_back(e);
    endtask

    task automatic apply(input bit r, input bit s, input bit f, input bit [3:0] a,
                         input bit [3:0] mi, input bit [3:0] fi, input bit [3:0] rd);
        @(negedge clk);
        rst   = r;
        stall = s;
        flush = f;
        act   = a;
        miss  = mi;
        fill  = fi;
        redir = rd;
        model_step(r, s, f, a, mi, fi, rd);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (o_valid !== e.valid || o_grant !== e.grant || o_thread !== e.thread) begin
                miscompares++;
                $display("FAIL grant vec %0d t=%0t: valid/grant/thread got %b/%b/%0d want %b/%b/%0d",
                         vectors, $time, o_valid, o_grant, o_thread, e.valid, e.grant, e.thread);
            end
        end
    end

    initial begin
        bit [3:0] ra;
        rst = 1; stall = 0; flush = 0; act = 4'h0; miss = 4'h0; fill = 4'h0; redir = 4'h0;

        // Reset, then steady round-robin over all four threads
        repeat (3) apply(1, 0, 0, 4'hF, 0, 0, 0);
        repeat (8) apply(0, 0, 0, 4'hF, 0, 0, 0);

        // Thread 1 misses, fill arrives five cycles later
        apply(0, 0, 0, 4'hF, 4'b0010, 0, 0);
        repeat (4) apply(0, 0, 0, 4'hF, 0, 0, 0);
        apply(0, 0, 0, 4'hF, 0, 4'b0010, 0);
        repeat (6) apply(0, 0, 0, 4'hF, 0, 0, 0);

        // Only thread 2 active, redirect penalty
        repeat (2) apply(1, 0, 0, 4'b0100, 0, 0, 0);
        repeat (5) apply(0, 0, 0, 4'b0100, 0, 0, 0);
        apply(0, 0, 0, 4'b0100, 0, 0, 4'b0100);
        repeat (8) apply(0, 0, 0, 4'b0100, 0, 0, 0);

        // Stall for four cycles while thread 0's fill arrives
        repeat (2) apply(1, 0, 0, 4'hF, 0, 0, 0);
        repeat (6) apply(0, 0, 0, 4'hF, 0, 0, 0);
        apply(0, 0, 0, 4'hF, 4'b0001, 0, 0);
        apply(0, 0, 0, 4'hF, 0, 0, 0);
        apply(0, 1, 0, 4'hF, 0, 0, 0);
        apply(0, 1, 0, 4'hF, 0, 4'b0001, 0);
        repeat (2) apply(0, 1, 0, 4'hF, 0, 0, 0);
        repeat (6) apply(0, 0, 0, 4'hF, 0, 0, 0);

        // Flush together with stall, then flush alone
        repeat (3) apply(0, 0, 0, 4'hF, 0, 0, 0);
        repeat (2) apply(0, 1, 1, 4'hF, 0, 0, 0);
        apply(0, 0, 1, 4'hF, 0, 0, 0);
        repeat (5) apply(0, 0, 0, 4'hF, 0, 0, 0);

        // Reset while thread 3 is in its penalty
        apply(0, 0, 0, 4'hF, 0, 0, 4'b1000);
        apply(0, 0, 0, 4'hF, 0, 0, 0);
        apply(1, 0, 0, 4'hF, 0, 0, 0);
        repeat (6) apply(0, 0, 0, 4'hF, 0, 0, 0);

        // Random traffic
        ra = 4'hF;
        for (int c = 0; c < 3000; c++) begin
            bit [3:0] mi, fi, rd;
            bit       s, f, r;
            if ($urandom_range(0, 49) == 0) ra = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) begin
                mi[i] = ($urandom_range(0, 15) == 0);
                fi[i] = ($urandom_range(0, 7) == 0);
                rd[i] = ($urandom_range(0, 31) == 0);
            end
            s = ($urandom_range(0, 7) == 0);
            f = ($urandom_range(0, 15) == 0);
            r = ($urandom_range(0, 299) == 0);
            apply(r, s, f, ra, mi, fi, rd);
        end

        apply(0, 0, 0, 4'hF, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
